// File: rtl/token_avg_pool_pkg.sv
// token_avg_pool shared definitions.
// Token width, window size and pooling FSM states.
package token_avg_pool_pkg;

  localparam int att_width   = 16;
  localparam int POOL_TOKENS = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } pool_state_t;

endpackage

// File: rtl/pool_round_shift.sv
// Signed round-half-up divide by 2^SHIFT.
// Adds half an LSB of the result, then arithmetic-shifts.
module pool_round_shift #(
  parameter int IN_W  = 21,
  parameter int SHIFT = 4,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  in_val,
  output logic signed [OUT_W-1:0] out_val
);

  localparam logic [IN_W-1:0] HALF =
    {{(IN_W-1){1'b0}}, 1'b1} << (SHIFT-1);

  logic signed [IN_W-1:0] biased;

  assign biased  = in_val + $signed(HALF);
  assign out_val = OUT_W'(biased >>> SHIFT);

endmodule

// File: rtl/token_avg_pool.sv
// Token average pool: sums TOKENS signed tokens and
// emits their rounded mean over a valid/ready handshake.
module token_avg_pool
  import token_avg_pool_pkg::*;
#(
  parameter int DATA_W = att_width,
  parameter int TOKENS = POOL_TOKENS,
  parameter int LOG2_T = $clog2(TOKENS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     busy,
  output logic                     err_overrun
);

  localparam int AW = DATA_W + LOG2_T + 1;
  localparam logic [LOG2_T-1:0] LAST =
    LOG2_T'(TOKENS-1);

  pool_state_t              state_q, state_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [LOG2_T-1:0]        cnt_q, cnt_d;
  logic signed [DATA_W-1:0] od_q, od_d;
  logic                     ov_q, ov_d;
  logic                     err_q, err_d;

  logic signed [AW-1:0]     tok_ext;
  logic signed [AW-1:0]     sum;
  logic signed [DATA_W-1:0] rounded;
  logic                     accept;

  assign tok_ext = {{(AW-DATA_W){in_data[DATA_W-1]}}, in_data};
  assign sum     = acc_q + tok_ext;

  pool_round_shift #(
    .IN_W  (AW),
    .SHIFT (LOG2_T),
    .OUT_W (DATA_W)
  ) u_round (
    .in_val  (sum),
    .out_val (rounded)
  );

  assign in_ready    = (state_q != HOLD);
  assign accept      = en & in_valid & in_ready;
  assign busy        = (state_q != IDLE);
  assign out_valid   = ov_q;
  assign out_data    = od_q;
  assign err_overrun = err_q;

  // Next-state and datapath update; clr overrides everything.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    od_d    = od_q;
    ov_d    = ov_q;
    err_d   = err_q | (en & in_valid & ~in_ready);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = tok_ext;
          cnt_d   = LOG2_T'(1);
          state_d = ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_d = sum;
          cnt_d = cnt_q + LOG2_T'(1);
          if (cnt_q == LAST) begin
            od_d    = rounded;
            ov_d    = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (ov_q & out_ready) begin
          ov_d    = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      od_d    = '0;
      ov_d    = 1'b0;
      err_d   = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      od_q    <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      od_q    <= od_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
    end
  end

endmodule
